// File: rtl/write_channel_arbiter_pkg.sv
// Shared transaction-layer constants and types for the write-channel arbiter.
// Connection-count limits, payload widths and the connection-id width live here.
package write_channel_arbiter_pkg;

  localparam int NUM_CONN_MIN = 2;
  localparam int NUM_CONN_MAX = 16;
  localparam int NUM_CONN_DEF = 4;
  localparam int AW_W_DEF     = 84;
  localparam int W_W_DEF      = 144;
  localparam int CONN_ID_W    = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Successor of a connection index, wrapping at num_conn.
  function automatic logic [CONN_ID_W-1:0] next_conn(input logic [CONN_ID_W-1:0] idx,
                                                     input int num_conn);
    if (int'(idx) >= num_conn - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/write_channel_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting index at or after i_ptr,
// wrapping, returned both one-hot and as an index.
module rr_picker
  import write_channel_arbiter_pkg::*;
#(
  parameter int N = NUM_CONN_DEF
) (
  input  logic [N-1:0]         i_req,
  input  logic [CONN_ID_W-1:0] i_ptr,
  output logic [N-1:0]         o_grant,
  output logic [CONN_ID_W-1:0] o_idx,
  output logic                 o_any
);

  // Scan from the farthest offset down so the candidate closest to i_ptr wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_grant = N'(1) << ((int'(i_ptr) + k) % N);
        o_idx   = CONN_ID_W'((int'(i_ptr) + k) % N);
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/write_channel_arbiter.sv
// Grants one connection at a time the AW/W path to the width converter and
// passes its handshakes through combinationally until the last W beat.
module write_channel_arbiter
  import write_channel_arbiter_pkg::*;
#(
  parameter int NUM_CONN = NUM_CONN_DEF,
  parameter int AW_W     = AW_W_DEF,
  parameter int W_W      = W_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CONN*AW_W-1:0] s_aw,
  input  logic [NUM_CONN-1:0]      s_aw_valid,
  output logic [NUM_CONN-1:0]      s_aw_ready,
  input  logic [NUM_CONN*W_W-1:0]  s_w,
  input  logic [NUM_CONN-1:0]      s_w_last,
  input  logic [NUM_CONN-1:0]      s_w_valid,
  output logic [NUM_CONN-1:0]      s_w_ready,
  input  logic [NUM_CONN-1:0]      conn_enable,
  output logic [AW_W-1:0]          aw,
  output logic [CONN_ID_W-1:0]     aw_connection_id,
  output logic                     aw_valid,
  input  logic                     aw_ready,
  output logic [W_W-1:0]           w,
  output logic                     w_last,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic                     busy,
  output logic [NUM_CONN-1:0]      grant
);

  arb_state_e            r_state;
  arb_state_e            w_state_next;
  logic [NUM_CONN-1:0]   r_grant;
  logic [CONN_ID_W-1:0]  r_conn_id;
  logic [CONN_ID_W-1:0]  r_rr_ptr;
  logic                  r_aw_done;

  logic [NUM_CONN-1:0]   w_eligible;
  logic [NUM_CONN-1:0]   w_pick_grant;
  logic [CONN_ID_W-1:0]  w_pick_idx;
  logic                  w_pick_any;
  logic                  w_aw_hs;
  logic                  w_w_last_hs;
  logic [AW_W-1:0]       w_aw_masked [NUM_CONN];
  logic [W_W-1:0]        w_w_masked  [NUM_CONN];

  // AW is only accepted alongside the first W beat, so both valids must be up.
  assign w_eligible = s_aw_valid & s_w_valid & conn_enable;

  rr_picker #(
    .N (NUM_CONN)
  ) u_rr_picker (
    .i_req   (w_eligible),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // One-hot AND-OR mux: a non-granted payload can never leak to the outputs.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CONN; gi++) begin : g_mask
      assign w_aw_masked[gi] = {AW_W{r_grant[gi]}} & s_aw[gi*AW_W +: AW_W];
      assign w_w_masked[gi]  = {W_W{r_grant[gi]}} & s_w[gi*W_W +: W_W];
    end
  endgenerate

  assign w_aw_hs     = aw_valid & aw_ready;
  assign w_w_last_hs = w_valid & w_ready & w_last;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_pick_any)  w_state_next = ST_BUSY;
      ST_BUSY: if (w_w_last_hs) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    aw         = '0;
    w          = '0;
    w_last     = 1'b0;
    aw_valid   = 1'b0;
    w_valid    = 1'b0;
    s_aw_ready = '0;
    s_w_ready  = '0;
    busy       = 1'b0;
    if (r_state == ST_BUSY) begin
      busy = 1'b1;
      for (int i = 0; i < NUM_CONN; i++) begin
        aw = aw | w_aw_masked[i];
        w  = w | w_w_masked[i];
      end
      w_last     = |(r_grant & s_w_last);
      aw_valid   = (|(r_grant & s_aw_valid)) & ~r_aw_done;
      w_valid    = |(r_grant & s_w_valid);
      s_aw_ready = r_grant & {NUM_CONN{aw_ready & ~r_aw_done}};
      s_w_ready  = r_grant & {NUM_CONN{w_ready}};
    end
  end

  assign grant            = r_grant;
  assign aw_connection_id = r_conn_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant   <= '0;
      r_conn_id <= '0;
      r_rr_ptr  <= '0;
      r_aw_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_grant   <= w_pick_grant;
            r_conn_id <= w_pick_idx;
            r_aw_done <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (w_w_last_hs) begin
            r_grant   <= '0;
            r_rr_ptr  <= next_conn(r_conn_id, NUM_CONN);
            r_aw_done <= 1'b0;
          end else if (w_aw_hs) begin
            r_aw_done <= 1'b1;
          end
        end
        default: r_grant <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_write_channel_arbiter.sv
// Bench for write_channel_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a round-robin transaction-level model.
module tb_write_channel_arbiter;

  localparam int N    = 4;
  localparam int AW_W = 84;
  localparam int W_W  = 144;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [N*AW_W-1:0] s_aw;
  logic [N-1:0]      s_aw_valid, s_aw_ready;
  logic [N*W_W-1:0]  s_w;
  logic [N-1:0]      s_w_last, s_w_valid, s_w_ready, conn_enable;
  logic [AW_W-1:0]   aw;
  logic [3:0]        aw_connection_id;
  logic              aw_valid, aw_ready;
  logic [W_W-1:0]    w;
  logic              w_last, w_valid, w_ready, busy;
  logic [N-1:0]      grant;

  write_channel_arbiter #(.NUM_CONN(N), .AW_W(AW_W), .W_W(W_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .s_aw             (s_aw),
    .s_aw_valid       (s_aw_valid),
    .s_aw_ready       (s_aw_ready),
    .s_w              (s_w),
    .s_w_last         (s_w_last),
    .s_w_valid        (s_w_valid),
    .s_w_ready        (s_w_ready),
    .conn_enable      (conn_enable),
    .aw               (aw),
    .aw_connection_id (aw_connection_id),
    .aw_valid         (aw_valid),
    .aw_ready         (aw_ready),
    .w                (w),
    .w_last           (w_last),
    .w_valid          (w_valid),
    .w_ready          (w_ready),
    .busy             (busy),
    .grant            (grant)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: idle/held grant, owner index, AW-sent flag, rotation pointer.
  bit m_busy = 0;
  bit m_aw_done = 0;
  int m_g = 0;
  int m_rr = 0;
  int m_grant_log[$];
  bit check_en = 0;

  initial begin
    int c;
    bit aw_hs, w_end;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_busy = 0; m_aw_done = 0; m_rr = 0;
      end else if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          c = (m_rr + k) % N;
          if (s_aw_valid[c] && s_w_valid[c] && conn_enable[c]) begin
            m_busy = 1; m_g = c; m_aw_done = 0;
            m_grant_log.push_back(c);
            break;
          end
        end
      end else begin
        aw_hs = s_aw_valid[m_g] && !m_aw_done && aw_ready;
        w_end = s_w_valid[m_g] && w_ready && s_w_last[m_g];
        if (w_end) begin
          m_busy = 0; m_aw_done = 0; m_rr = (m_g + 1) % N;
        end else if (aw_hs) begin
          m_aw_done = 1;
        end
      end
    end
  end

  // Per-cycle compare of every DUT output against the model.
  initial begin
    logic [N-1:0] oh;
    bit exp_awv, exp_wv;
    forever begin
      @(negedge clk);
      if (check_en) begin
        oh      = m_busy ? (N'(1) << m_g) : '0;
        exp_awv = m_busy && s_aw_valid[m_g] && !m_aw_done;
        exp_wv  = m_busy && s_w_valid[m_g];
        chk("busy", busy, m_busy);
        chk("grant", grant, oh);
        chk("aw_valid", aw_valid, exp_awv);
        chk("w_valid", w_valid, exp_wv);
        chk("s_aw_ready", s_aw_ready, (aw_ready && !m_aw_done) ? oh : '0);
        chk("s_w_ready", s_w_ready, w_ready ? oh : '0);
        if (m_busy) chk("aw_connection_id", aw_connection_id, m_g);
        if (exp_awv) chk("aw", aw, s_aw[m_g*AW_W +: AW_W]);
        if (exp_wv) begin
          chk("w", w, s_w[m_g*W_W +: W_W]);
          chk("w_last", w_last, s_w_last[m_g]);
        end
      end
    end
  end

  // Requester behaviour
  int burst_left[N];
  bit aw_pend[N];
  bit aw_block[N];
  bit rand_mode = 0;
  int dut_aw_hs = 0;
  int dut_w_hs = 0;
  logic         snap_busy;
  logic [N-1:0] snap_grant, snap_awr, snap_wr;
  logic [3:0]   snap_id;

  task automatic drive();
    logic [159:0] t;
    for (int i = 0; i < N; i++) begin
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      s_aw[i*AW_W +: AW_W] = t[AW_W-1:0];
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      s_w[i*W_W +: W_W] = t[W_W-1:0];
      s_aw_valid[i] = aw_pend[i] && !aw_block[i] && (!rand_mode || $urandom_range(3) != 0);
      s_w_valid[i]  = (burst_left[i] > 0) && (!rand_mode || $urandom_range(3) != 0);
      s_w_last[i]   = (burst_left[i] == 1);
      if (rand_mode) conn_enable[i] = ($urandom_range(7) != 0);
    end
    if (rand_mode) begin
      aw_ready = ($urandom_range(3) != 0);
      w_ready  = ($urandom_range(3) != 0);
    end
  endtask

  task automatic step();
    logic [N-1:0] awhs, whs;
    logic ahs, wh;
    drive();
    @(negedge clk);
    snap_busy = busy; snap_grant = grant; snap_id = aw_connection_id;
    snap_awr = s_aw_ready; snap_wr = s_w_ready;
    awhs = s_aw_valid & s_aw_ready;
    whs  = s_w_valid & s_w_ready;
    ahs  = aw_valid & aw_ready;
    wh   = w_valid & w_ready;
    @(posedge clk);
    #1;
    if (reset) begin
      for (int i = 0; i < N; i++) begin burst_left[i] = 0; aw_pend[i] = 0; end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (awhs[i]) aw_pend[i] = 0;
        if (whs[i] && burst_left[i] > 0) burst_left[i]--;
      end
      dut_aw_hs += int'(ahs);
      dut_w_hs  += int'(wh);
    end
  endtask

  task automatic arm(input int i, input int len);
    burst_left[i] = len;
    aw_pend[i] = 1;
  endtask

  task automatic clear_req();
    for (int i = 0; i < N; i++) begin burst_left[i] = 0; aw_pend[i] = 0; aw_block[i] = 0; end
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (burst_left[i] != 0) return 0;
    return 1;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while (!all_done() && n < 200) begin step(); n++; end
    step();
    chk(name, {255'b0, all_done()}, 256'd1);
  endtask

  initial begin
    int n;
    bit seen;
    int starts[$];
    int ids[$];
    int exp_order[4] = '{0, 1, 3, 0};
    logic prev;

    reset = 1; s_aw = '0; s_w = '0; s_aw_valid = '0; s_w_valid = '0; s_w_last = '0;
    conn_enable = '1; aw_ready = 1; w_ready = 1;
    clear_req();
    step();
    check_en = 1;
    step();
    reset = 0;
    step();
    chk("reset_busy", snap_busy, 0);
    chk("reset_grant", snap_grant, 0);
    chk("reset_id", snap_id, 0);

    // Single 4-beat burst on connection 2
    dut_aw_hs = 0; dut_w_hs = 0; seen = 0; n = 0;
    arm(2, 4);
    while (burst_left[2] != 0 && n < 20) begin
      step(); n++;
      if (snap_busy && !seen) begin
        seen = 1;
        chk("s1_grant", snap_grant, 4'b0100);
        chk("s1_id", snap_id, 2);
      end
    end
    chk("s1_done", burst_left[2], 0);
    chk("s1_aw_count", dut_aw_hs, 1);
    chk("s1_w_count", dut_w_hs, 4);
    step();
    chk("s1_busy_drop", snap_busy, 0);
    chk("s1_model_rr", m_rr, 3);
    arm(2, 1); arm(3, 1);
    step(); step();
    chk("s1_rr_pick", snap_id, 3);
    drain("s1_drain");

    // Continuous contention on 0, 1, 3 from rr_ptr=0 with single-beat bursts
    reset = 1; step(); reset = 0;
    clear_req();
    m_grant_log.delete();
    arm(0, 1); arm(1, 1); arm(3, 1);
    prev = 0;
    for (int j = 0; j < 8; j++) begin
      step();
      if (snap_busy && !prev) begin starts.push_back(j); ids.push_back(int'(snap_id)); end
      prev = snap_busy;
      for (int i = 0; i < N; i++) if (i != 2 && burst_left[i] == 0) arm(i, 1);
    end
    chk("s2_count", ids.size(), 4);
    for (int k = 0; k < 4 && k < ids.size(); k++) begin
      chk("s2_order", ids[k], exp_order[k]);
      chk("s2_model_order", m_grant_log[k], exp_order[k]);
      if (k > 0) chk("s2_gap", starts[k] - starts[k-1], 2);
    end
    clear_req();
    step(); step();

    // W valid without AW: no grant until AW shows up
    arm(1, 2); aw_block[1] = 1;
    repeat (4) begin step(); chk("s3_no_grant", snap_busy, 0); end
    aw_block[1] = 0;
    step(); chk("s3_arb_cycle", snap_busy, 0);
    step(); chk("s3_granted", snap_busy, 1); chk("s3_id", snap_id, 1);
    drain("s3_drain");

    // Converter backpressure mid-burst
    dut_aw_hs = 0; dut_w_hs = 0;
    arm(0, 6);
    step(); step();
    arm(2, 1);
    w_ready = 0;
    repeat (5) begin
      step();
      chk("s4_stall_ready", snap_wr, 0);
      chk("s4_stall_grant", snap_grant, 4'b0001);
    end
    w_ready = 1;
    n = 0;
    while (burst_left[0] != 0 && n < 20) begin step(); n++; end
    chk("s4_w_count", dut_w_hs, 6);
    chk("s4_aw_count", dut_aw_hs, 1);
    drain("s4_drain");

    // conn_enable gating in IDLE, ignored during BUSY
    conn_enable[0] = 0;
    arm(0, 2);
    repeat (3) begin step(); chk("s5_disabled", snap_busy, 0); end
    conn_enable[0] = 1;
    step(); step();
    chk("s5_granted", snap_busy, 1);
    chk("s5_id", snap_id, 0);
    conn_enable[0] = 0;
    n = 0;
    while (burst_left[0] != 0 && n < 20) begin step(); n++; end
    chk("s5_completed", burst_left[0], 0);
    conn_enable = '1;
    step();

    // Reset in the middle of an 8-beat burst
    dut_w_hs = 0;
    arm(1, 8);
    n = 0;
    while (dut_w_hs < 2 && n < 20) begin step(); n++; end
    chk("s6_reached_beat2", dut_w_hs, 2);
    reset = 1; step(); reset = 0;
    arm(1, 8);
    step();
    chk("s6_busy", snap_busy, 0);
    chk("s6_grant", snap_grant, 0);
    chk("s6_aw_ready", snap_awr, 0);
    chk("s6_w_ready", snap_wr, 0);
    drain("s6_drain");

    // Randomized traffic with occasional resets
    rand_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (burst_left[i] == 0 && $urandom_range(2) == 0) arm(i, int'($urandom_range(6, 1)));
      reset = ($urandom_range(299) == 0);
      step();
    end
    reset = 0;
    rand_mode = 0;
    aw_ready = 1; w_ready = 1; conn_enable = '1;
    for (int i = 0; i < N; i++) aw_pend[i] = (burst_left[i] != 0);
    drain("rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/write_channel_arbiter.md
WRITE_CHANNEL_ARBITER -- requirements
Module: write_channel_arbiter

Interface
REQ-001 Parameter NUM_CONN, default 4, number of requesting connections; legal range 2..16.
REQ-002 Parameter AW_W, default 84, AW payload width, including context id and channel num.
REQ-003 Parameter W_W, default 144, W payload width, w_strb plus w_data.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 s_aw  input  NUM_CONN*AW_W  per-connection AW payload; slice i belongs to connection i.
REQ-007 s_aw_valid / s_aw_ready  input / output  NUM_CONN each  per-connection AW handshake.
REQ-008 s_w  input  NUM_CONN*W_W  per-connection W payload.
REQ-009 s_w_last / s_w_valid / s_w_ready  input / input / output  NUM_CONN each  per-connection W last flag and handshake.
REQ-010 conn_enable  input  NUM_CONN  per-connection arbitration enable; sampled only in IDLE.
REQ-011 aw  output  AW_W  granted AW payload to the width converter.
REQ-012 aw_connection_id  output  4  index of the granted connection.
REQ-013 aw_valid / aw_ready  output / input  1 each  AW handshake with the converter.
REQ-014 w / w_last  output  W_W / 1  granted W payload and last flag.
REQ-015 w_valid / w_ready  output / input  1 each  W handshake with the converter.
REQ-016 busy  output  1  high while a grant is held.
REQ-017 grant  output  NUM_CONN  one-hot registered grant; all zeros in IDLE.

Function
REQ-018 The FSM SHALL have two states, IDLE and BUSY; reset state is IDLE.
REQ-019 In IDLE, connection i SHALL be eligible when s_aw_valid[i], s_w_valid[i] and conn_enable[i] are all high; both are required because the converter accepts AW only together with the first W beat.
REQ-020 In IDLE with at least one eligible connection, the block SHALL register the grant as follows and enter BUSY on the next edge (1-cycle arbitration latency):
- pick the first eligible index searching round-robin from pointer rr_ptr;
- set grant one-hot, set aw_connection_id to the index, clear aw_done.
REQ-021 In IDLE, aw_valid, w_valid, all s_aw_ready and all s_w_ready SHALL be 0.
REQ-022 In BUSY with granted index g, the block SHALL be combinational pass-through with zero latency:
- aw = s_aw[g]; aw_valid = s_aw_valid[g] & ~aw_done;
- w = s_w[g]; w_last = s_w_last[g]; w_valid = s_w_valid[g];
- s_aw_ready[g] = aw_ready & ~aw_done; s_w_ready[g] = w_ready;
- all non-granted ready bits = 0.
REQ-023 aw_done SHALL set on the AW handshake and stay set until the grant is released; exactly one AW SHALL pass per grant.
REQ-024 The grant SHALL be released on the W handshake with w_last=1:
- next state IDLE, rr_ptr = (g+1) mod NUM_CONN, grant cleared;
- the W and AW handshakes may occur in the same cycle, giving a single-beat burst.
REQ-025 A new grant SHALL NOT be issued in the release cycle; the minimum gap between bursts is 1 idle cycle.
REQ-026 Payload of a non-granted connection SHALL never reach aw or w; the mux output is don't-care when valid is 0.
REQ-027 Deasserting conn_enable[g] during BUSY SHALL NOT abort the burst.
REQ-028 The block SHALL hold no data storage; backpressure from the converter (aw_ready/w_ready low) SHALL propagate to the granted requester in the same cycle.

Reset
REQ-029 On reset the block SHALL clear state (IDLE), grant (0), rr_ptr (0), aw_done (0), busy (0) and aw_connection_id (0); all valid and ready outputs SHALL be 0 in the following cycle.
REQ-030 A reset mid-burst SHALL drop the grant without completing the burst; requesters and the converter are reset in the same cycle.

Structure
REQ-031 NUM_CONN limits, AW_W, W_W and the 4-bit connection-id width SHALL be constants in the shared transaction-layer package.
REQ-032 The round-robin priority picker SHALL be one sub-module, rr_picker (request vector plus pointer in, one-hot grant and index out, purely combinational).

Verification
REQ-033 Scenario: after reset, conn 2 presents AW and 4 W beats, converter always ready -> grant=0100, aw_connection_id=2, exactly 1 AW and 4 W handshakes, busy drops after the last beat, rr_ptr=3.
REQ-034 Scenario: conns 0, 1 and 3 all eligible continuously with rr_ptr=0, 1-beat bursts -> grants issue in order 0,1,3,0, with one idle cycle between bursts.
REQ-035 Scenario: conn 1 has s_w_valid=1 but s_aw_valid=0 -> no grant; once AW arrives, grant appears 1 cycle later.
REQ-036 Scenario: converter holds w_ready=0 for 5 cycles mid-burst -> s_w_ready[g]=0 for those cycles, no beat is lost or duplicated, and other connections stay ungranted.
REQ-037 Scenario: conn_enable[0]=0 while conn 0 is eligible -> no grant; conn_enable[0] dropped mid-burst -> burst still completes.
REQ-038 Scenario: reset asserted at beat 2 of 8 -> next cycle busy=0, grant=0, all ready outputs 0.
